// File: rtl/multi_cycle_control_pkg.sv
// rtl/multi_cycle_control_pkg.sv - shared opcode header: opcodes, ALU codes, FSM states and control bundle
package multi_cycle_control_pkg;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] JMP   = 6'b000010;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] ANDI  = 6'b001100;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // aluOp codes shared with the ALU control decoder
    localparam logic [1:0] AluOpType_ADD    = 2'b00;
    localparam logic [1:0] AluOpType_SUB    = 2'b01;
    localparam logic [1:0] AluOpType_FUNCT  = 2'b10;
    localparam logic [1:0] AluOpType_OPCODE = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
    } state_e;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic [1:0] pcSource;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic       zeroExt;
        logic [1:0] aluOp;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multi_cycle_control_if.sv
// rtl/multi_cycle_control_if.sv - controller-to-datapath control bus
interface multi_cycle_control_if;
    logic [5:0] opcode;
    logic       memReady;
    logic       pcWrite;
    logic       pcWriteCond;
    logic [1:0] pcSource;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       zeroExt;
    logic [1:0] aluOp;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, memReady,
        output pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, zeroExt, aluOp, illegal, state
    );

    modport slave (
        output opcode, memReady,
        input  pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, zeroExt, aluOp, illegal, state
    );
endinterface

// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle MIPS main control FSM
module multi_cycle_control
    import multi_cycle_control_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    multi_cycle_control_if.master  bus
);

    state_e state_q, state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (bus.memReady) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    LW, SW:     state_d = S_MEM_ADDR;
                    RTYPE:      state_d = S_R_EXEC;
                    BEQ:        state_d = S_BRANCH;
                    JMP:        state_d = S_JUMP;
                    ADDI, ANDI: state_d = S_I_EXEC;
                    default:    state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (bus.opcode == SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (bus.memReady) state_d = S_MEM_WB;
            S_MEM_WRITE: if (bus.memReady) state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.memRead = 1'b1;
                ctrl.aluSrcB = ALUB_FOUR;
                ctrl.aluOp   = AluOpType_ADD;
                if (bus.memReady) begin
                    ctrl.irWrite  = 1'b1;
                    ctrl.pcWrite  = 1'b1;
                    ctrl.pcSource = PCSRC_ALU;
                end
            end
            S_DECODE: begin
                ctrl.aluSrcB = ALUB_IMM_SH2;
                ctrl.aluOp   = AluOpType_ADD;
                case (bus.opcode)
                    LW, SW, RTYPE, BEQ, JMP, ADDI, ANDI: ctrl.illegal = 1'b0;
                    default:                            ctrl.illegal = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = ALUB_IMM;
            end
            S_MEM_READ: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = ALUB_REG;
                ctrl.aluOp   = AluOpType_FUNCT;
            end
            S_R_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluSrcB     = ALUB_REG;
                ctrl.aluOp       = AluOpType_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCSRC_JUMP;
            end
            S_I_EXEC, S_I_WB: begin
                // ALU selects held through write-back so ALUOut stays valid
                ctrl.aluSrcA  = 1'b1;
                ctrl.aluSrcB  = ALUB_IMM;
                ctrl.aluOp    = (bus.opcode == ANDI) ? AluOpType_OPCODE : AluOpType_ADD;
                ctrl.zeroExt  = (bus.opcode == ANDI);
                ctrl.regWrite = (state_q == S_I_WB);
            end
            default: ctrl = '0;
        endcase
        if (rst) ctrl = '0;
    end

    assign bus.pcWrite     = ctrl.pcWrite;
    assign bus.pcWriteCond = ctrl.pcWriteCond;
    assign bus.pcSource    = ctrl.pcSource;
    assign bus.iorD        = ctrl.iorD;
    assign bus.memRead     = ctrl.memRead;
    assign bus.memWrite    = ctrl.memWrite;
    assign bus.irWrite     = ctrl.irWrite;
    assign bus.memToReg    = ctrl.memToReg;
    assign bus.regDst      = ctrl.regDst;
    assign bus.regWrite    = ctrl.regWrite;
    assign bus.aluSrcA     = ctrl.aluSrcA;
    assign bus.aluSrcB     = ctrl.aluSrcB;
    assign bus.zeroExt     = ctrl.zeroExt;
    assign bus.aluOp       = ctrl.aluOp;
    assign bus.illegal     = ctrl.illegal;
    assign bus.state       = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb/tb_multi_cycle_control.sv - directed self-checking bench for multi_cycle_control
module tb_multi_cycle_control;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;

    multi_cycle_control_if bif ();

    multi_cycle_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master)
    );

    always #5 clk = ~clk;

    logic [21:0] all_out;
    assign all_out = {bif.pcWrite, bif.pcWriteCond, bif.pcSource, bif.iorD, bif.memRead,
                      bif.memWrite, bif.irWrite, bif.memToReg, bif.regDst, bif.regWrite,
                      bif.aluSrcA, bif.aluSrcB, bif.zeroExt, bif.aluOp, bif.illegal, bif.state};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bif.memReady = 1'b1; bif.opcode = 6'b000000;
        step();
        step();
        n_total++;
        if (all_out !== 22'd0) $display("FAIL reset_outputs got %h want 000000", all_out);
        else n_pass++;
        n_total++;
        if (bif.state !== 4'd0) $display("FAIL reset_state got %0d want 0", bif.state);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if ({bif.memRead, bif.aluSrcB, bif.iorD, bif.aluSrcA} !== 5'b10100)
            $display("FAIL first_fetch got %b want 10100", {bif.memRead, bif.aluSrcB, bif.iorD, bif.aluSrcA});
        else n_pass++;
    endtask

    task automatic test_fetch_wait();
        bif.memReady = 1'b0;
        #1;
        n_total++;
        if ({bif.memRead, bif.irWrite, bif.pcWrite} !== 3'b100)
            $display("FAIL fetch_wait_strobes got %b want 100", {bif.memRead, bif.irWrite, bif.pcWrite});
        else n_pass++;
        step();
        n_total++;
        if (bif.state !== 4'd0) $display("FAIL fetch_wait_state got %0d want 0", bif.state);
        else n_pass++;
        bif.memReady = 1'b1;
        #1;
        n_total++;
        if ({bif.irWrite, bif.pcWrite, bif.pcSource} !== 4'b1100)
            $display("FAIL fetch_ready got %b want 1100", {bif.irWrite, bif.pcWrite, bif.pcSource});
        else n_pass++;
    endtask

    task automatic test_rtype();
        bif.opcode = 6'b000000; bif.memReady = 1'b1;
        step();
        n_total++;
        if ({bif.state, bif.aluSrcB, bif.illegal} !== {4'd1, 2'b11, 1'b0})
            $display("FAIL rtype_decode got %0d/%b/%b want 1/11/0", bif.state, bif.aluSrcB, bif.illegal);
        else n_pass++;
        bif.memReady = 1'b0;
        step();
        n_total++;
        if ({bif.state, bif.aluOp, bif.aluSrcA, bif.aluSrcB} !== {4'd6, 2'b10, 1'b1, 2'b00})
            $display("FAIL rtype_exec got %0d/%b/%b/%b want 6/10/1/00", bif.state, bif.aluOp, bif.aluSrcA, bif.aluSrcB);
        else n_pass++;
        step();
        n_total++;
        if ({bif.state, bif.regWrite, bif.regDst, bif.memToReg} !== {4'd7, 3'b110})
            $display("FAIL rtype_wb got %0d/%b%b%b want 7/110", bif.state, bif.regWrite, bif.regDst, bif.memToReg);
        else n_pass++;
        step();
        n_total++;
        if (bif.state !== 4'd0) $display("FAIL rtype_return got %0d want 0", bif.state);
        else n_pass++;
    endtask

    task automatic test_lw_wait();
        int cyc;
        bif.opcode = 6'b100011; bif.memReady = 1'b1;
        cyc = 1;
        step(); cyc++;
        step(); cyc++;
        n_total++;
        if ({bif.state, bif.aluSrcA, bif.aluSrcB} !== {4'd2, 1'b1, 2'b10})
            $display("FAIL lw_addr got %0d/%b/%b want 2/1/10", bif.state, bif.aluSrcA, bif.aluSrcB);
        else n_pass++;
        step(); cyc++;
        bif.memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bif.memReady = 1'b1;
            #1;
            n_total++;
            if ({bif.state, bif.memRead, bif.iorD} !== {4'd3, 2'b11})
                $display("FAIL lw_read_hold_%0d got %0d/%b%b want 3/11", i, bif.state, bif.memRead, bif.iorD);
            else n_pass++;
            step(); cyc++;
        end
        n_total++;
        if ({bif.state, bif.memToReg, bif.regWrite, bif.regDst} !== {4'd4, 3'b110})
            $display("FAIL lw_wb got %0d/%b%b%b want 4/110", bif.state, bif.memToReg, bif.regWrite, bif.regDst);
        else n_pass++;
        step();
        n_total++;
        if ({bif.state, cyc[3:0]} !== {4'd0, 4'd7})
            $display("FAIL lw_cycles got state %0d cycles %0d want 0/7", bif.state, cyc);
        else n_pass++;
    endtask

    task automatic test_beq_jump();
        int cyc;
        bif.opcode = 6'b000100; bif.memReady = 1'b1;
        step(); step();
        n_total++;
        if ({bif.state, bif.pcWriteCond, bif.aluOp, bif.pcSource, bif.pcWrite} !== {4'd8, 1'b1, 2'b01, 2'b01, 1'b0})
            $display("FAIL beq_branch got %0d/%b/%b/%b/%b want 8/1/01/01/0", bif.state, bif.pcWriteCond, bif.aluOp, bif.pcSource, bif.pcWrite);
        else n_pass++;
        step();
        n_total++;
        if (bif.state !== 4'd0) $display("FAIL beq_return got %0d want 0", bif.state);
        else n_pass++;
        bif.opcode = 6'b000010;
        cyc = 0;
        do begin
            step(); cyc++;
            if (bif.state == 4'd9) begin
                n_total++;
                if ({bif.pcWrite, bif.pcSource, bif.pcWriteCond} !== 4'b1100)
                    $display("FAIL jump_ctrl got %b want 1100", {bif.pcWrite, bif.pcSource, bif.pcWriteCond});
                else n_pass++;
            end
        end while (bif.state != 4'd0 && cyc < 20);
        n_total++;
        if (cyc !== 3) $display("FAIL jump_cycles got %0d want 3", cyc);
        else n_pass++;
    endtask

    task automatic test_imm();
        logic [5:0] ops [2]   = '{6'b001100, 6'b001000};
        logic [2:0] want [2]  = '{3'b111, 3'b000};
        for (int k = 0; k < 2; k++) begin
            bif.opcode = ops[k]; bif.memReady = 1'b1;
            step(); step();
            n_total++;
            if ({bif.state, bif.aluOp, bif.zeroExt, bif.regWrite} !== {4'd10, want[k], 1'b0})
                $display("FAIL imm_exec_%0d got %0d/%b/%b/%b want 10/%b/0", k, bif.state, bif.aluOp, bif.zeroExt, bif.regWrite, want[k]);
            else n_pass++;
            step();
            n_total++;
            if ({bif.state, bif.aluOp, bif.zeroExt, bif.regWrite, bif.aluSrcA, bif.aluSrcB, bif.regDst}
                !== {4'd11, want[k], 1'b1, 1'b1, 2'b10, 1'b0})
                $display("FAIL imm_wb_%0d got %0d/%b/%b/%b/%b/%b want 11/%b/1/1/10/0", k, bif.state, bif.aluOp, bif.zeroExt, bif.regWrite, bif.aluSrcA, bif.aluSrcB, want[k]);
            else n_pass++;
            step();
            n_total++;
            if (bif.state !== 4'd0) $display("FAIL imm_return_%0d got %0d want 0", k, bif.state);
            else n_pass++;
        end
    endtask

    task automatic test_illegal_and_reset_wait();
        bif.opcode = 6'b111111; bif.memReady = 1'b1;
        step();
        n_total++;
        if ({bif.state, bif.illegal} !== {4'd1, 1'b1})
            $display("FAIL illegal_pulse got %0d/%b want 1/1", bif.state, bif.illegal);
        else n_pass++;
        step();
        n_total++;
        if ({bif.state, bif.illegal} !== {4'd0, 1'b0})
            $display("FAIL illegal_return got %0d/%b want 0/0", bif.state, bif.illegal);
        else n_pass++;
        bif.opcode = 6'b101011;
        step(); step(); step();
        bif.memReady = 1'b0;
        #1;
        n_total++;
        if ({bif.state, bif.memWrite, bif.iorD, bif.memRead} !== {4'd5, 3'b110})
            $display("FAIL sw_wait got %0d/%b%b%b want 5/110", bif.state, bif.memWrite, bif.iorD, bif.memRead);
        else n_pass++;
        step();
        rst = 1'b1;
        step();
        n_total++;
        if ({bif.state, bif.memWrite} !== {4'd0, 1'b0})
            $display("FAIL reset_in_wait got %0d/%b want 0/0", bif.state, bif.memWrite);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if ({bif.state, bif.memRead, bif.memWrite} !== {4'd0, 2'b10})
            $display("FAIL after_reset_fetch got %0d/%b%b want 0/10", bif.state, bif.memRead, bif.memWrite);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        bif.opcode = 6'd0;
        bif.memReady = 1'b0;
        test_reset();
        test_fetch_wait();
        test_rtype();
        test_lw_wait();
        test_beq_jump();
        test_imm();
        test_illegal_and_reset_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
